branch_hazard_unit: RTL and testbench
=====================================

Name: branch_hazard_unit

Overview:
- ID-stage hazard and stall controller for the 5-stage MIPS pipeline, which resolves branches in ID.
- It is the producer side of the branch-forwarding contract. It creates the guarantee the branch forwarding unit relies on: 1 stall for an ALU result feeding a branch, 2 stalls for a load feeding a branch, and 1 stall for an ordinary load-use.
- It also issues the IF/ID flush for taken branches and keeps a stall-cycle performance counter.

Parameters:
- CNT_WIDTH, 32, width of the StallCount performance counter.

Ports:
- clk  in  1  pipeline clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- Branch  in  2  ID-stage branch type; 2'b00 means not a branch.
- BranchTaken  in  1  ID-stage branch comparison result.
- IF_ID_RegisterRs  in  5  rs of the instruction in ID.
- IF_ID_RegisterRt  in  5  rt of the instruction in ID.
- ID_EX_RegWrite  in  1  instruction in EX writes a register.
- ID_EX_MemRead  in  1  instruction in EX is a load.
- ID_EX_RegisterRd  in  5  destination register of the instruction in EX (already muxed rt/rd).
- EX_MEM_MemRead  in  1  instruction in MEM is a load.
- EX_MEM_RegisterRd  in  5  destination register of the instruction in MEM.
- PCWrite  out  1  PC update enable.
- IF_ID_Write  out  1  IF/ID register enable.
- ID_EX_Flush  out  1  inject a bubble into ID/EX.
- IF_ID_Flush  out  1  squash the fetched instruction after a taken branch.
- HazardState  out  2  current FSM state, for debug.
- StallCount  out  CNT_WIDTH  total stall cycles since reset.

Behaviour:
- Definitions:
  - match(X) = (X != 0) && (X == IF_ID_RegisterRs || X == IF_ID_RegisterRt).
  - isBr = (Branch != 2'b00).
- Detection terms:
  - LB = isBr && ID_EX_MemRead && match(ID_EX_RegisterRd)  (load feeding a branch).
  - AB = isBr && ID_EX_RegWrite && !ID_EX_MemRead && match(ID_EX_RegisterRd)  (ALU result feeding a branch).
  - MB = isBr && EX_MEM_MemRead && match(EX_MEM_RegisterRd)  (load in MEM feeding a branch).
  - LU = !isBr && ID_EX_MemRead && match(ID_EX_RegisterRd)  (ordinary load-use).
- FSM states: IDLE=2'b00, STALL1=2'b01. Encodings 2'b10 and 2'b11 are illegal and recover to IDLE on the next edge.
- IDLE:
  - stall = LB | AB | MB | LU. This is Mealy: combinational in the same cycle.
  - Next state is STALL1 if LB, otherwise IDLE.
- STALL1:
  - stall = 1 unconditionally; detection terms are ignored.
  - Next state is IDLE.
- Stall counts per hazard: LB gives exactly 2 consecutive stall cycles. AB, MB and LU each give exactly 1.
- Overlap priority: LB dominates. Simultaneous AB and MB gives 1 stall. Rs and Rt both matching counts as a single event.
- Output equations:
  - PCWrite = !stall.
  - IF_ID_Write = !stall.
  - ID_EX_Flush = stall.
  - IF_ID_Flush = BranchTaken && isBr && !stall. BranchTaken is ignored while stalling because the branch operands are not yet valid.
- StallCount increments by 1 on each rising edge where stall = 1 and reset = 0. It saturates at all-ones and does not wrap.
- Reset:
  - While reset is high: state = IDLE, StallCount = 0, PCWrite = 1, IF_ID_Write = 1, ID_EX_Flush = 0, IF_ID_Flush = 0, HazardState = 2'b00. The outputs are gated by reset, not only by state.
  - Reset asserted in STALL1 drops the stall immediately (asynchronous). After release the FSM starts in IDLE.
- Register $0 never causes a stall.

Decomposition:
- Shared package (pipeline defs) holds:
  - Branch encodings: BR_NONE = 2'b00, BR_BEQ, BR_BNE.
  - Hazard state constants: HZ_IDLE, HZ_STALL1.
  - REG_ZERO = 5'd0.
- One natural sub-module: hazard_stall_counter, the saturating CNT_WIDTH counter with increment enable and asynchronous clear. Detection logic and the FSM stay in the top module.

Test Plan:
- Load then branch: ID_EX_MemRead=1, ID_EX_RegWrite=1, ID_EX_RegisterRd=8; Branch=01, Rs=8, Rt=9. Required: stall for cycles N and N+1 (PCWrite=0, ID_EX_Flush=1), HazardState 00→01→00, StallCount 0→2, and IF_ID_Flush=0 throughout even with BranchTaken=1.
- ALU then branch: ID_EX_RegWrite=1, MemRead=0, Rd=9, Branch=10, Rt=9. Required: exactly 1 stall cycle, state stays 00, StallCount +1. Then with Rd=0 and Rs=Rt=0: no stall.
- Load in MEM feeding a branch (lw, nop, beq): EX_MEM_MemRead=1, EX_MEM_RegisterRd=5, Branch=01, Rs=5. Required: 1 stall. Simultaneous AB on Rt is also 1 stall only.
- Non-branch load-use: Branch=00, ID_EX_MemRead=1, Rd=3, Rt=3. Required: 1 stall. The same inputs with Branch=00 and MemRead=0 give no stall.
- Taken branch, no hazard: Branch=01, BranchTaken=1, no matches. Required: IF_ID_Flush=1, PCWrite=1, ID_EX_Flush=0.
- Reset while in STALL1. Required: outputs go to reset values asynchronously and HazardState=00. Also preload StallCount near saturation (force CNT_WIDTH=4, issue 20 stall cycles). Required: StallCount holds at 4'hF.

Source files
------------

// File: rtl/branch_hazard_unit_pkg.sv
// ---------------------------------------------------------------------------
// branch_hazard_unit_pkg
//
// Purpose:
//   Shared pipeline definitions for the ID-stage hazard/stall controller of
//   the 5-stage MIPS pipeline (branches resolved in ID).
//
// Contents:
//   BR_NONE/BR_BEQ/BR_BNE  ID-stage branch type encodings
//   hazardState_t          FSM state type (HZ_IDLE, HZ_STALL1)
//   REG_ZERO               architectural register $0
//   regMatch()             "producer register feeds a consumer operand" test
// ---------------------------------------------------------------------------
package branch_hazard_unit_pkg;

    // Branch type carried by the instruction in ID; anything other than
    // BR_NONE is a branch whose operands are compared in ID.
    localparam logic [1:0] BR_NONE = 2'b00;
    localparam logic [1:0] BR_BEQ  = 2'b01;
    localparam logic [1:0] BR_BNE  = 2'b10;

    // Register $0 is hardwired to zero, so writing it never creates a hazard.
    localparam logic [4:0] REG_ZERO = 5'd0;

    // Hazard FSM states. The two remaining 2-bit encodings are illegal and
    // are steered back to HZ_IDLE by the FSM.
    typedef enum logic [1:0] {
        HZ_IDLE   = 2'b00,
        HZ_STALL1 = 2'b01
    } hazardState_t;

    // True when a producer destination register is a real register and is
    // read by either source operand of the instruction in ID. Rs and Rt
    // matching together still yields a single hazard event.
    function automatic logic regMatch(
        input logic [4:0] dest,
        input logic [4:0] rs,
        input logic [4:0] rt
    );
        return (dest != REG_ZERO) && ((dest == rs) || (dest == rt));
    endfunction

endpackage

// File: rtl/branch_hazard_unit_if.sv
// ---------------------------------------------------------------------------
// branch_hazard_unit_if
//
// Purpose:
//   Bundles the pipeline-side signals seen by the ID-stage hazard unit and
//   the control signals it returns to the pipeline.
//
// Signals (pipeline -> hazard unit):
//   Branch, BranchTaken             ID-stage branch type and comparison result
//   IF_ID_RegisterRs/Rt             source registers of the instruction in ID
//   ID_EX_RegWrite/MemRead/RegisterRd  producer in EX
//   EX_MEM_MemRead/RegisterRd       producer in MEM
// Signals (hazard unit -> pipeline):
//   PCWrite, IF_ID_Write            fetch/decode enables
//   ID_EX_Flush, IF_ID_Flush        bubble injection and taken-branch squash
//   HazardState                     FSM state for debug
//   StallCount                      stall-cycle performance counter
//
// Modports:
//   master  pipeline side (drives the ID/EX/MEM information)
//   slave   hazard unit side
// ---------------------------------------------------------------------------
interface branch_hazard_unit_if #(
    parameter int CNT_WIDTH = 32
);

    logic [1:0]           Branch;
    logic                 BranchTaken;
    logic [4:0]           IF_ID_RegisterRs;
    logic [4:0]           IF_ID_RegisterRt;
    logic                 ID_EX_RegWrite;
    logic                 ID_EX_MemRead;
    logic [4:0]           ID_EX_RegisterRd;
    logic                 EX_MEM_MemRead;
    logic [4:0]           EX_MEM_RegisterRd;

    logic                 PCWrite;
    logic                 IF_ID_Write;
    logic                 ID_EX_Flush;
    logic                 IF_ID_Flush;
    logic [1:0]           HazardState;
    logic [CNT_WIDTH-1:0] StallCount;

    modport master (
        output Branch, BranchTaken, IF_ID_RegisterRs, IF_ID_RegisterRt,
               ID_EX_RegWrite, ID_EX_MemRead, ID_EX_RegisterRd,
               EX_MEM_MemRead, EX_MEM_RegisterRd,
        input  PCWrite, IF_ID_Write, ID_EX_Flush, IF_ID_Flush,
               HazardState, StallCount
    );

    modport slave (
        input  Branch, BranchTaken, IF_ID_RegisterRs, IF_ID_RegisterRt,
               ID_EX_RegWrite, ID_EX_MemRead, ID_EX_RegisterRd,
               EX_MEM_MemRead, EX_MEM_RegisterRd,
        output PCWrite, IF_ID_Write, ID_EX_Flush, IF_ID_Flush,
               HazardState, StallCount
    );

endinterface

// File: rtl/branch_hazard_unit_stall_counter.sv
// ---------------------------------------------------------------------------
// hazard_stall_counter
//
// Purpose:
//   Saturating stall-cycle counter. Counts rising edges on which 'inc' is
//   high and sticks at all-ones instead of wrapping, so a long run never
//   reports a misleadingly small number.
//
// Ports:
//   clk    in   pipeline clock
//   reset  in   asynchronous active-high clear
//   inc    in   count this cycle
//   count  out  WIDTH-bit saturating count
// ---------------------------------------------------------------------------
module hazard_stall_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic atMax;

    // All-ones detection gates further increments once the counter is full.
    always_comb begin
        atMax = &count;
    end

    // Counter register: cleared asynchronously, increments while enabled
    // and not yet saturated.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (inc && !atMax) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/branch_hazard_unit.sv
// ---------------------------------------------------------------------------
// branch_hazard_unit
//
// Purpose:
//   ID-stage hazard and stall controller for a 5-stage MIPS pipeline that
//   resolves branches in ID. Guarantees the branch forwarding unit:
//     - 1 stall for an ALU result in EX feeding a branch
//     - 2 stalls for a load in EX feeding a branch
//     - 1 stall for a load in MEM feeding a branch
//     - 1 stall for an ordinary load-use
//   Also squashes IF/ID after a taken branch and counts stall cycles.
//
// Ports:
//   clk    in  pipeline clock
//   reset  in  asynchronous active-high reset
//   bus    slave side of branch_hazard_unit_if (see interface header)
//
// Parameters:
//   CNT_WIDTH  width of StallCount; must match the interface instance
// ---------------------------------------------------------------------------
module branch_hazard_unit
    import branch_hazard_unit_pkg::*;
#(
    parameter int CNT_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    branch_hazard_unit_if.slave    bus
);

    hazardState_t         state;
    logic                 isBr;
    logic                 loadBranch;
    logic                 aluBranch;
    logic                 memLoadBranch;
    logic                 loadUse;
    logic                 hazard;
    logic                 stall;
    logic [CNT_WIDTH-1:0] stallCount;

    // Hazard detection terms. A load in EX feeding a branch is the only case
    // that needs a second stall cycle, since the loaded value is not
    // forwardable to ID until it has reached WB.
    always_comb begin
        isBr          = (bus.Branch != BR_NONE);
        loadBranch    = isBr && bus.ID_EX_MemRead &&
                        regMatch(bus.ID_EX_RegisterRd,
                                 bus.IF_ID_RegisterRs, bus.IF_ID_RegisterRt);
        aluBranch     = isBr && bus.ID_EX_RegWrite && !bus.ID_EX_MemRead &&
                        regMatch(bus.ID_EX_RegisterRd,
                                 bus.IF_ID_RegisterRs, bus.IF_ID_RegisterRt);
        memLoadBranch = isBr && bus.EX_MEM_MemRead &&
                        regMatch(bus.EX_MEM_RegisterRd,
                                 bus.IF_ID_RegisterRs, bus.IF_ID_RegisterRt);
        loadUse       = !isBr && bus.ID_EX_MemRead &&
                        regMatch(bus.ID_EX_RegisterRd,
                                 bus.IF_ID_RegisterRs, bus.IF_ID_RegisterRt);
        hazard        = loadBranch | aluBranch | memLoadBranch | loadUse;
    end

    // Stall decision. In IDLE the stall follows the detection terms in the
    // same cycle; in STALL1 the second load-to-branch bubble is forced
    // regardless of inputs. Reset kills the stall immediately so the
    // pipeline comes out of reset fetching.
    always_comb begin
        stall = 1'b0;
        if (!reset) begin
            case (state)
                HZ_STALL1: stall = 1'b1;
                HZ_IDLE:   stall = hazard;
                default:   stall = 1'b0;
            endcase
        end
    end

    // FSM: only a load feeding a branch moves to STALL1, and STALL1 always
    // returns to IDLE. Illegal encodings fall back to IDLE on the next edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= HZ_IDLE;
        end else begin
            case (state)
                HZ_IDLE:   state <= loadBranch ? HZ_STALL1 : HZ_IDLE;
                HZ_STALL1: state <= HZ_IDLE;
                default:   state <= HZ_IDLE;
            endcase
        end
    end

    hazard_stall_counter #(
        .WIDTH (CNT_WIDTH)
    ) stallCounter (
        .clk   (clk),
        .reset (reset),
        .inc   (stall),
        .count (stallCount)
    );

    // Pipeline control outputs. BranchTaken is ignored while stalling because
    // the branch operands are not yet valid; everything is forced to its
    // free-running value while reset is high.
    always_comb begin
        bus.PCWrite     = !stall;
        bus.IF_ID_Write = !stall;
        bus.ID_EX_Flush = stall;
        bus.IF_ID_Flush = !reset && bus.BranchTaken && isBr && !stall;
        bus.HazardState = reset ? HZ_IDLE : state;
        bus.StallCount  = stallCount;
    end

endmodule

// File: tb/tb_branch_hazard_unit.sv
// ---------------------------------------------------------------------------
// tb_branch_hazard_unit
//
// Directed-vector bench for branch_hazard_unit. A 32-bit counter instance and
// a 4-bit counter instance see identical pipeline inputs; the narrow one
// exercises StallCount saturation.
// ---------------------------------------------------------------------------
module tb_branch_hazard_unit;
    import branch_hazard_unit_pkg::*;

    logic clk;
    logic reset;

    logic [1:0] branch;
    logic       branchTaken;
    logic [4:0] ifIdRs;
    logic [4:0] ifIdRt;
    logic       idExRegWrite;
    logic       idExMemRead;
    logic [4:0] idExRd;
    logic       exMemMemRead;
    logic [4:0] exMemRd;

    int vectorCount;
    int missCount;

    branch_hazard_unit_if #(.CNT_WIDTH(32)) bus ();
    branch_hazard_unit_if #(.CNT_WIDTH(4))  busSmall ();

    assign bus.Branch                 = branch;
    assign bus.BranchTaken            = branchTaken;
    assign bus.IF_ID_RegisterRs       = ifIdRs;
    assign bus.IF_ID_RegisterRt       = ifIdRt;
    assign bus.ID_EX_RegWrite         = idExRegWrite;
    assign bus.ID_EX_MemRead          = idExMemRead;
    assign bus.ID_EX_RegisterRd       = idExRd;
    assign bus.EX_MEM_MemRead         = exMemMemRead;
    assign bus.EX_MEM_RegisterRd      = exMemRd;

    assign busSmall.Branch            = branch;
    assign busSmall.BranchTaken       = branchTaken;
    assign busSmall.IF_ID_RegisterRs  = ifIdRs;
    assign busSmall.IF_ID_RegisterRt  = ifIdRt;
    assign busSmall.ID_EX_RegWrite    = idExRegWrite;
    assign busSmall.ID_EX_MemRead     = idExMemRead;
    assign busSmall.ID_EX_RegisterRd  = idExRd;
    assign busSmall.EX_MEM_MemRead    = exMemMemRead;
    assign busSmall.EX_MEM_RegisterRd = exMemRd;

    branch_hazard_unit #(.CNT_WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    branch_hazard_unit #(.CNT_WIDTH(4)) dutSmall (
        .clk   (clk),
        .reset (reset),
        .bus   (busSmall.slave)
    );

    // 10-time-unit clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one full set of ID/EX/MEM pipeline inputs.
    task automatic applyStimulus(
        input logic [1:0] br,
        input logic       taken,
        input logic [4:0] rs,
        input logic [4:0] rt,
        input logic       exRegWrite,
        input logic       exMemRead,
        input logic [4:0] exRd,
        input logic       memMemRead,
        input logic [4:0] memRd
    );
        branch       = br;
        branchTaken  = taken;
        ifIdRs       = rs;
        ifIdRt       = rt;
        idExRegWrite = exRegWrite;
        idExMemRead  = exMemRead;
        idExRd       = exRd;
        exMemMemRead = memMemRead;
        exMemRd      = memRd;
        #1;
    endtask

    // Advance to just after the next rising edge.
    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    // Single comparison point for the whole bench.
    task automatic checkOutput(
        input string       tag,
        input logic [31:0] observed,
        input logic [31:0] expected
    );
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Check the four pipeline control outputs for a given stall/flush pair.
    task automatic checkControl(
        input string tag,
        input logic  expStall,
        input logic  expIfIdFlush
    );
        checkOutput({tag, ".PCWrite"},     {31'd0, bus.PCWrite},     {31'd0, !expStall});
        checkOutput({tag, ".IF_ID_Write"}, {31'd0, bus.IF_ID_Write}, {31'd0, !expStall});
        checkOutput({tag, ".ID_EX_Flush"}, {31'd0, bus.ID_EX_Flush}, {31'd0, expStall});
        checkOutput({tag, ".IF_ID_Flush"}, {31'd0, bus.IF_ID_Flush}, {31'd0, expIfIdFlush});
    endtask

    initial begin
        vectorCount = 0;
        missCount   = 0;
        reset       = 1'b1;
        applyStimulus(BR_NONE, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
        stepCycle();
        stepCycle();

        // Reset values, including with a load-use and a taken branch present.
        checkControl("reset", 1'b0, 1'b0);
        checkOutput("reset.state", {30'd0, bus.HazardState}, 32'd0);
        checkOutput("reset.count", bus.StallCount, 32'd0);
        checkOutput("reset.countSmall", {28'd0, busSmall.StallCount}, 32'd0);
        applyStimulus(BR_NONE, 1'b0, 5'd3, 5'd3, 1'b1, 1'b1, 5'd3, 1'b0, 5'd0);
        checkControl("resetGateLU", 1'b0, 1'b0);
        applyStimulus(BR_BEQ, 1'b1, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
        checkControl("resetGateTaken", 1'b0, 1'b0);
        applyStimulus(BR_NONE, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
        reset = 1'b0;
        stepCycle();
        checkOutput("afterReset.count", bus.StallCount, 32'd0);

        // Load in EX feeding a branch: two stalls, FSM 00 -> 01 -> 00.
        applyStimulus(BR_BEQ, 1'b1, 5'd8, 5'd9, 1'b1, 1'b1, 5'd8, 1'b0, 5'd0);
        checkControl("lb.c0", 1'b1, 1'b0);
        checkOutput("lb.c0.state", {30'd0, bus.HazardState}, 32'd0);
        stepCycle();
        applyStimulus(BR_BEQ, 1'b1, 5'd8, 5'd9, 1'b0, 1'b0, 5'd0, 1'b1, 5'd8);
        checkControl("lb.c1", 1'b1, 1'b0);
        checkOutput("lb.c1.state", {30'd0, bus.HazardState}, 32'd1);
        checkOutput("lb.c1.count", bus.StallCount, 32'd1);
        stepCycle();
        applyStimulus(BR_BEQ, 1'b1, 5'd8, 5'd9, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
        checkControl("lb.c2", 1'b0, 1'b1);
        checkOutput("lb.c2.state", {30'd0, bus.HazardState}, 32'd0);
        checkOutput("lb.c2.count", bus.StallCount, 32'd2);
        applyStimulus(BR_NONE, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
        stepCycle();

        // ALU result in EX feeding a bne on Rt: one stall, state stays IDLE.
        applyStimulus(BR_BNE, 1'b0, 5'd4, 5'd9, 1'b1, 1'b0, 5'd9, 1'b0, 5'd0);
        checkControl("ab.c0", 1'b1, 1'b0);
        stepCycle();
        applyStimulus(BR_BNE, 1'b0, 5'd4, 5'd9, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
        checkControl("ab.c1", 1'b0, 1'b0);
        checkOutput("ab.c1.state", {30'd0, bus.HazardState}, 32'd0);
        checkOutput("ab.c1.count", bus.StallCount, 32'd3);
        applyStimulus(BR_BNE, 1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0);
        checkControl("ab.reg0", 1'b0, 1'b0);
        stepCycle();
        checkOutput("ab.reg0.count", bus.StallCount, 32'd3);

        // Load in MEM feeding a branch: one stall.
        applyStimulus(BR_BEQ, 1'b0, 5'd5, 5'd7, 1'b0, 1'b0, 5'd0, 1'b1, 5'd5);
        checkControl("mb.c0", 1'b1, 1'b0);
        stepCycle();
        checkOutput("mb.c1.count", bus.StallCount, 32'd4);
        applyStimulus(BR_BEQ, 1'b0, 5'd5, 5'd7, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
        checkControl("mb.c1", 1'b0, 1'b0);

        // Load in MEM on Rs plus ALU result in EX on Rt: still a single stall.
        applyStimulus(BR_BEQ, 1'b0, 5'd5, 5'd6, 1'b1, 1'b0, 5'd6, 1'b1, 5'd5);
        checkControl("abmb.c0", 1'b1, 1'b0);
        stepCycle();
        checkOutput("abmb.c1.state", {30'd0, bus.HazardState}, 32'd0);
        checkOutput("abmb.c1.count", bus.StallCount, 32'd5);
        applyStimulus(BR_BEQ, 1'b0, 5'd5, 5'd6, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
        checkControl("abmb.c1", 1'b0, 1'b0);
        stepCycle();

        // Ordinary load-use with Rs and Rt both matching: one stall event.
        applyStimulus(BR_NONE, 1'b0, 5'd3, 5'd3, 1'b1, 1'b1, 5'd3, 1'b0, 5'd0);
        checkControl("lu.c0", 1'b1, 1'b0);
        stepCycle();
        checkOutput("lu.c1.state", {30'd0, bus.HazardState}, 32'd0);
        checkOutput("lu.c1.count", bus.StallCount, 32'd6);
        applyStimulus(BR_NONE, 1'b0, 5'd3, 5'd3, 1'b1, 1'b0, 5'd3, 1'b0, 5'd0);
        checkControl("lu.noMemRead", 1'b0, 1'b0);
        applyStimulus(BR_NONE, 1'b0, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0);
        checkControl("lu.reg0", 1'b0, 1'b0);

        // Taken branch without hazard squashes IF/ID; a taken flag on a
        // non-branch does nothing.
        applyStimulus(BR_BEQ, 1'b1, 5'd1, 5'd2, 1'b1, 1'b0, 5'd7, 1'b1, 5'd10);
        checkControl("taken", 1'b0, 1'b1);
        applyStimulus(BR_NONE, 1'b1, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
        checkControl("takenNoBranch", 1'b0, 1'b0);
        stepCycle();
        checkOutput("taken.count", bus.StallCount, 32'd6);

        // Asynchronous reset while in STALL1.
        applyStimulus(BR_BEQ, 1'b1, 5'd8, 5'd9, 1'b1, 1'b1, 5'd8, 1'b0, 5'd0);
        stepCycle();
        checkOutput("rst.preState", {30'd0, bus.HazardState}, 32'd1);
        reset = 1'b1;
        #1;
        checkControl("rst.inStall1", 1'b0, 1'b0);
        checkOutput("rst.inStall1.state", {30'd0, bus.HazardState}, 32'd0);
        checkOutput("rst.inStall1.count", bus.StallCount, 32'd0);
        applyStimulus(BR_NONE, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
        stepCycle();
        reset = 1'b0;
        stepCycle();
        checkOutput("rst.after.state", {30'd0, bus.HazardState}, 32'd0);
        checkControl("rst.after", 1'b0, 1'b0);

        // Saturation: 20 consecutive ALU-to-branch stall cycles.
        applyStimulus(BR_BNE, 1'b0, 5'd9, 5'd0, 1'b1, 1'b0, 5'd9, 1'b0, 5'd0);
        for (int i = 0; i < 14; i++) stepCycle();
        checkOutput("sat.small14", {28'd0, busSmall.StallCount}, 32'd14);
        for (int i = 0; i < 6; i++) stepCycle();
        checkOutput("sat.small20", {28'd0, busSmall.StallCount}, 32'hF);
        checkOutput("sat.wide20", bus.StallCount, 32'd20);
        applyStimulus(BR_NONE, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
        stepCycle();
        checkOutput("sat.hold", {28'd0, busSmall.StallCount}, 32'hF);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
